// File: rtl/fourth_step_if.sv
// fourth_step_if: execution-stage inputs and memory/write-back outputs of fourth_step.
// slave modport is the fourth_step side, master modport is the driver/observer side.
`timescale 1ns/1ps
interface fourth_step_if;
  logic        memRead;
  logic        memWrite;
  logic        branch;
  logic        regWrite;
  logic        memToReg;
  logic [31:0] addResult;
  logic [31:0] aluResult;
  logic        zero;
  logic [31:0] reg2Out;
  logic [4:0]  muxRegDstOut;
  logic        flush;
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic        memStall;
  logic        wbRegWrite;
  logic        wbMemToReg;
  logic [31:0] wbReadData;
  logic [31:0] wbAluResult;
  logic [4:0]  wbRegDst;
  logic        memAddrError;

  modport slave (
    input  memRead, memWrite, branch, regWrite, memToReg,
    input  addResult, aluResult, zero, reg2Out, muxRegDstOut, flush,
    output pcSrc, branchTarget, memStall,
    output wbRegWrite, wbMemToReg, wbReadData, wbAluResult, wbRegDst, memAddrError
  );

  modport master (
    output memRead, memWrite, branch, regWrite, memToReg,
    output addResult, aluResult, zero, reg2Out, muxRegDstOut, flush,
    input  pcSrc, branchTarget, memStall,
    input  wbRegWrite, wbMemToReg, wbReadData, wbAluResult, wbRegDst, memAddrError
  );
endinterface

// File: rtl/fourth_step.sv
// fourth_step: EX/MEM register, 256x32 data memory and MEM/WB register.
// Define DMEM_WAIT_STATE_EN to add one wait state to every aligned memory access.
`timescale 1ns/1ps
module fourth_step (
  input  logic          clk,
  input  logic          reset,
  fourth_step_if.slave  bus
);
  localparam int unsigned DW    = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned IW    = 8;
  localparam int unsigned DEPTH = 256;

  // EX/MEM register
  logic          r_mem_read, r_mem_write, r_branch, r_reg_write, r_mem_to_reg, r_zero;
  logic [DW-1:0] r_add_result, r_alu_result, r_reg2;
  logic [RW-1:0] r_reg_dst;

  // MEM/WB register
  logic          r_wb_reg_write, r_wb_mem_to_reg, r_mem_addr_error;
  logic [DW-1:0] r_wb_read_data, r_wb_alu_result;
  logic [RW-1:0] r_wb_reg_dst;

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_access, w_misaligned, w_load, w_stall, w_complete;
  logic [IW-1:0] w_index;

  assign w_access     = r_mem_read | r_mem_write;
  assign w_misaligned = w_access && (r_alu_result[1:0] != 2'b00);
  assign w_index      = r_alu_result[9:2];
  // read+write together behaves as a store, so only a pure aligned read loads
  assign w_load       = r_mem_read && !r_mem_write && !w_misaligned;

`ifdef DMEM_WAIT_STATE_EN
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
  state_t r_state;

  // aligned accesses hold the pipeline for one cycle in IDLE; misaligned ones complete at once
  assign w_stall = (r_state == S_IDLE) && w_access && !w_misaligned;

  // wait-state sequencer: IDLE -> WAIT on a stalled access, WAIT always completes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= w_stall ? S_WAIT : S_IDLE;
        S_WAIT:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  assign w_complete = !w_stall;

  assign bus.memStall     = w_stall;
  assign bus.pcSrc        = r_branch & r_zero;
  assign bus.branchTarget = r_add_result;

  assign bus.wbRegWrite   = r_wb_reg_write;
  assign bus.wbMemToReg   = r_wb_mem_to_reg;
  assign bus.wbReadData   = r_wb_read_data;
  assign bus.wbAluResult  = r_wb_alu_result;
  assign bus.wbRegDst     = r_wb_reg_dst;
  assign bus.memAddrError = r_mem_addr_error;

  // EX/MEM capture; flush turns control bits into a bubble, stall holds everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_zero       <= 1'b0;
      r_add_result <= '0;
      r_alu_result <= '0;
      r_reg2       <= '0;
      r_reg_dst    <= '0;
    end else if (!w_stall) begin
      r_mem_read   <= bus.memRead  & ~bus.flush;
      r_mem_write  <= bus.memWrite & ~bus.flush;
      r_branch     <= bus.branch   & ~bus.flush;
      r_reg_write  <= bus.regWrite & ~bus.flush;
      r_mem_to_reg <= bus.memToReg;
      r_zero       <= bus.zero;
      r_add_result <= bus.addResult;
      r_alu_result <= bus.aluResult;
      r_reg2       <= bus.reg2Out;
      r_reg_dst    <= bus.muxRegDstOut;
    end
  end

  // data memory write port (contents survive reset; reset aborts a pending store)
  always_ff @(posedge clk) begin
    if (!reset && w_complete && r_mem_write && !w_misaligned) begin
      r_mem[w_index] <= r_reg2;
    end
  end

  // MEM/WB update on completing edges, bubble otherwise
  always_ff @(posedge clk) begin
    if (reset || !w_complete) begin
      r_wb_reg_write   <= 1'b0;
      r_wb_mem_to_reg  <= 1'b0;
      r_wb_read_data   <= '0;
      r_wb_alu_result  <= '0;
      r_wb_reg_dst     <= '0;
      r_mem_addr_error <= 1'b0;
    end else begin
      r_wb_reg_write   <= r_reg_write && !w_misaligned;
      r_wb_mem_to_reg  <= r_mem_to_reg;
      r_wb_read_data   <= w_load ? r_mem[w_index] : DW'(0);
      r_wb_alu_result  <= r_alu_result;
      r_wb_reg_dst     <= r_reg_dst;
      r_mem_addr_error <= w_misaligned;
    end
  end
endmodule

// File: tb/tb_fourth_step.sv
// tb_fourth_step: directed self-checking bench for fourth_step.
`timescale 1ns/1ps
module tb_fourth_step;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  fourth_step_if bus ();

  fourth_step dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic br, input logic rw,
                       input logic m2r, input logic [31:0] add, input logic [31:0] alu,
                       input logic z, input logic [31:0] r2, input logic [4:0] dst,
                       input logic fl);
    bus.memRead      = rd;
    bus.memWrite     = wr;
    bus.branch       = br;
    bus.regWrite     = rw;
    bus.memToReg     = m2r;
    bus.addResult    = add;
    bus.aluResult    = alu;
    bus.zero         = z;
    bus.reg2Out      = r2;
    bus.muxRegDstOut = dst;
    bus.flush        = fl;
  endtask

  task automatic clr();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 5'd0, 0);
  endtask

  // capture edge already done: let the access finish (extra edge if the memory stalls)
  task automatic done();
    clr();
    if (bus.memStall) tick();
    tick();
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    drive(0, 1, 0, 0, 0, 32'h0, addr, 0, data, 5'd0, 0);
    tick();
    done();
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] dst);
    drive(1, 0, 0, 1, 1, 32'h0, addr, 0, 32'h0, dst, 0);
    tick();
    done();
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // reset with a store presented: reset wins, nothing captured or written
    reset = 1'b1;
    drive(0, 1, 1, 1, 1, 32'h0040_0020, 32'h30, 1, 32'hAAAA_0000, 5'd9, 0);
    tick();
    tick();
    chk("rst_pcSrc",        32'(bus.pcSrc), 32'h0);
    chk("rst_branchTarget", bus.branchTarget, 32'h0);
    chk("rst_memStall",     32'(bus.memStall), 32'h0);
    chk("rst_wbRegWrite",   32'(bus.wbRegWrite), 32'h0);
    chk("rst_wbMemToReg",   32'(bus.wbMemToReg), 32'h0);
    chk("rst_wbReadData",   bus.wbReadData, 32'h0);
    chk("rst_wbAluResult",  bus.wbAluResult, 32'h0);
    chk("rst_wbRegDst",     32'(bus.wbRegDst), 32'h0);
    chk("rst_memAddrError", 32'(bus.memAddrError), 32'h0);
    reset = 1'b0;

    // known value at 0x30, then a store aborted by reset
    store(32'h30, 32'h0000_0055);
    drive(0, 1, 0, 0, 0, 32'h0, 32'h30, 0, 32'hFFFF_FFFF, 5'd0, 0);
    tick();
    if (bus.memStall) tick();
    reset = 1'b1;
    clr();
    tick();
    reset = 1'b0;
    chk("midrst_wbRegWrite", 32'(bus.wbRegWrite), 32'h0);
    chk("midrst_wbReadData", bus.wbReadData, 32'h0);
    chk("midrst_memStall",   32'(bus.memStall), 32'h0);
    load(32'h30, 5'd7);
    chk("midrst_nowrite",    bus.wbReadData, 32'h0000_0055);
    chk("ld30_wbRegWrite",   32'(bus.wbRegWrite), 32'h1);
    chk("ld30_wbMemToReg",   32'(bus.wbMemToReg), 32'h1);
    chk("ld30_wbRegDst",     32'(bus.wbRegDst), 32'd7);
    chk("ld30_wbAluResult",  bus.wbAluResult, 32'h30);

    // store 0x10 then load 0x10
    store(32'h10, 32'hDEAD_BEEF);
    chk("st_wbReadData",   bus.wbReadData, 32'h0);
    chk("st_wbRegWrite",   32'(bus.wbRegWrite), 32'h0);
    load(32'h10, 5'd3);
    chk("ld10_data",       bus.wbReadData, 32'hDEAD_BEEF);
    chk("ld10_wbRegWrite", 32'(bus.wbRegWrite), 32'h1);
    chk("ld10_wbRegDst",   32'(bus.wbRegDst), 32'd3);

`ifndef DMEM_WAIT_STATE_EN
    // exact two-edge latency from load capture to write-back
    drive(1, 0, 0, 1, 1, 32'h0, 32'h10, 0, 32'h0, 5'd4, 0);
    tick();
    clr();
    chk("lat_memStall",    32'(bus.memStall), 32'h0);
    chk("lat_edge1_data",  bus.wbReadData, 32'h0);
    tick();
    chk("lat_edge2_data",  bus.wbReadData, 32'hDEAD_BEEF);
    chk("lat_edge2_dst",   32'(bus.wbRegDst), 32'd4);
`endif

    // misaligned load: error pulse, no register write, no data
    load(32'h412, 5'd5);
    chk("mis_memAddrError", 32'(bus.memAddrError), 32'h1);
    chk("mis_wbRegWrite",   32'(bus.wbRegWrite), 32'h0);
    chk("mis_wbReadData",   bus.wbReadData, 32'h0);
    tick();
    chk("mis_pulse_end",    32'(bus.memAddrError), 32'h0);

    // address wraps modulo 1024 bytes
    load(32'h410, 5'd6);
    chk("wrap_data",        bus.wbReadData, 32'hDEAD_BEEF);
    chk("wrap_noerr",       32'(bus.memAddrError), 32'h0);

    // misaligned store must not write word 0x10
    store(32'h11, 32'h0000_9999);
    chk("mis_st_err",       32'(bus.memAddrError), 32'h1);
    load(32'h10, 5'd3);
    chk("mis_st_nowrite",   bus.wbReadData, 32'hDEAD_BEEF);

    // read+write together acts as a store with zero read data
    drive(1, 1, 0, 0, 0, 32'h0, 32'h40, 0, 32'h1111_2222, 5'd0, 0);
    tick();
    done();
    chk("rw_wbReadData",    bus.wbReadData, 32'h0);
    load(32'h40, 5'd2);
    chk("rw_stored",        bus.wbReadData, 32'h1111_2222);

    // branch resolution
    drive(0, 0, 1, 0, 0, 32'h0040_0020, 32'h0, 1, 32'h0, 5'd0, 0);
    tick();
    chk("br_taken_pcSrc",   32'(bus.pcSrc), 32'h1);
    chk("br_taken_target",  bus.branchTarget, 32'h0040_0020);
    drive(0, 0, 1, 0, 0, 32'h0040_0020, 32'h0, 0, 32'h0, 5'd0, 0);
    tick();
    chk("br_nottaken",      32'(bus.pcSrc), 32'h0);
    drive(0, 0, 1, 0, 0, 32'h0040_0040, 32'h0, 1, 32'h0, 5'd0, 1);
    tick();
    chk("br_flush_pcSrc",   32'(bus.pcSrc), 32'h0);
    chk("br_flush_target",  bus.branchTarget, 32'h0040_0040);

    // flushed store leaves memory unchanged; data fields still pass through
    store(32'h20, 32'hCAFE_0000);
    drive(0, 1, 0, 1, 0, 32'h0, 32'h20, 0, 32'h0000_1234, 5'd9, 1);
    tick();
    done();
    chk("fl_wbRegWrite",    32'(bus.wbRegWrite), 32'h0);
    chk("fl_wbAluResult",   bus.wbAluResult, 32'h20);
    chk("fl_wbRegDst",      32'(bus.wbRegDst), 32'd9);
    load(32'h20, 5'd1);
    chk("fl_mem_unchanged", bus.wbReadData, 32'hCAFE_0000);

`ifdef DMEM_WAIT_STATE_EN
    // one stall cycle, stall-cycle inputs dropped, one bubble in MEM/WB
    drive(1, 0, 0, 1, 1, 32'h0, 32'h10, 0, 32'h0, 5'd8, 0);
    tick();
    chk("ws_stall_hi",      32'(bus.memStall), 32'h1);
    drive(0, 0, 1, 1, 0, 32'h0000_0099, 32'h80, 1, 32'h0, 5'd5, 0);
    tick();
    chk("ws_stall_lo",      32'(bus.memStall), 32'h0);
    chk("ws_bubble",        32'(bus.wbRegWrite), 32'h0);
    chk("ws_not_captured",  32'(bus.pcSrc), 32'h0);
    clr();
    tick();
    chk("ws_ld_data",       bus.wbReadData, 32'hDEAD_BEEF);
    chk("ws_ld_dst",        32'(bus.wbRegDst), 32'd8);
    chk("ws_ld_regwrite",   32'(bus.wbRegWrite), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fourth_step.md
FOURTH_STEP -- requirements
Module: fourth_step

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 memRead, memWrite, branch, regWrite, memToReg  input  1 each  control bits from execution stage.
REQ-005 addResult  input  32  branch target; aluResult  input  32  ALU result / byte address; zero  input  1  ALU zero flag.
REQ-006 reg2Out  input  32  store data; muxRegDstOut  input  5  destination register.
REQ-007 flush  input  1  turns the capture at the next edge into a bubble.
REQ-008 pcSrc  output  1  branch taken; branchTarget  output  32  taken-branch PC.
REQ-009 memStall  output  1  upstream hold request.
REQ-010 wbRegWrite, wbMemToReg  output  1 each  write-back controls.
REQ-011 wbReadData, wbAluResult  output  32 each  loaded data and passed-through ALU result.
REQ-012 wbRegDst  output  5  write-back destination; memAddrError  output  1  one-cycle misalignment pulse.

Function
REQ-013 EX/MEM register SHALL capture all inputs on each rising edge when memStall=0, and hold when memStall=1.
REQ-014 flush=1 at a capture edge SHALL clear captured memRead, memWrite, branch and regWrite to 0; data fields captured normally; flush ignored while memStall=1.
REQ-015 pcSrc SHALL equal registered branch AND registered zero; branchTarget SHALL equal registered addResult; both combinational from EX/MEM, valid the cycle after capture.
REQ-016 Data memory SHALL be 256 x 32-bit, word index aluResult[9:2]; bits [31:10] ignored (address wraps modulo 1024 bytes).
REQ-017 Store: write reg2Out to the indexed word at the completing edge; memRead and memWrite both set SHALL act as store, wbReadData=0.
REQ-018 Load: synchronous read; wbReadData valid the cycle after the completing edge; non-load SHALL give wbReadData=0.
REQ-019 Misaligned access (aluResult[1:0]!=0 with memRead or memWrite) SHALL suppress the write, give wbReadData=0, force wbRegWrite=0, and pulse memAddrError for one cycle with the MEM/WB update.
REQ-020 MEM/WB register SHALL load wbRegWrite, wbMemToReg, wbAluResult, wbRegDst from EX/MEM at each completing edge; latency input-capture to write-back outputs = 2 edges with no stall.
REQ-021 Non-completing edges (stall cycle) SHALL load a bubble into MEM/WB: wbRegWrite=0, memAddrError=0.

Reset
REQ-022 reset=1 SHALL clear EX/MEM and MEM/WB registers and FSM to zero/IDLE at the edge: pcSrc=0, branchTarget=0, memStall=0, all wb outputs=0, memAddrError=0.
REQ-023 Memory contents SHALL NOT be reset; reset mid-access SHALL abort it with no write.
REQ-024 reset SHALL take priority over stall, flush and memory writes.

Configuration
REQ-025 Macro DMEM_WAIT_STATE_EN SHALL select single-wait-state memory.
REQ-026 With DMEM_WAIT_STATE_EN: FSM states IDLE, WAIT; in IDLE with registered memRead or memWrite set and address aligned, memStall=1 combinationally and the next edge goes to WAIT (non-completing); in WAIT memStall=0, the next edge completes the access and returns to IDLE; misaligned accesses complete from IDLE without stall.
REQ-027 Without DMEM_WAIT_STATE_EN: no FSM, memStall tied 0, every edge completes.

Verification
REQ-028 Store aluResult=0x10, reg2Out=0xDEADBEEF, then load aluResult=0x10, regWrite=1, memToReg=1 -> wbReadData=0xDEADBEEF, wbRegWrite=1, 2 edges after load capture (3 with DMEM_WAIT_STATE_EN).
REQ-029 Load aluResult=0x412 -> memAddrError pulse, wbRegWrite=0, wbReadData=0; load aluResult=0x410 -> returns data stored at 0x10 (wrap).
REQ-030 branch=1, zero=1, addResult=0x00400020 -> pcSrc=1, branchTarget=0x00400020 one cycle later; zero=0 -> pcSrc=0.
REQ-031 flush=1 with store to 0x20 of 0x1234 -> memory word 0x20 unchanged, wbRegWrite=0.
REQ-032 With DMEM_WAIT_STATE_EN, load followed by changing inputs -> memStall=1 exactly one cycle, inputs of the stall cycle not captured, one bubble in MEM/WB; reset asserted during WAIT on a store -> no write, outputs zero.
